// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: ULA operation
// codes, instruction field values and the control FSM state encoding.
package mips_pkg;

  localparam logic [3:0] ULA_AND = 4'd0;
  localparam logic [3:0] ULA_OR  = 4'd1;
  localparam logic [3:0] ULA_ADD = 4'd2;
  localparam logic [3:0] ULA_SUB = 4'd6;
  localparam logic [3:0] ULA_SLT = 4'd7;
  localparam logic [3:0] ULA_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  // What the ULA is being used for in the current state.
  typedef enum logic [2:0] {
    ULA_CLS_NONE   = 3'd0,
    ULA_CLS_ADD    = 3'd1,
    ULA_CLS_SUB    = 3'd2,
    ULA_CLS_DECODE = 3'd3,
    ULA_CLS_RTYPE  = 3'd4,
    ULA_CLS_ITYPE  = 3'd5
  } ula_cls_t;

endpackage

// File: rtl/ula_decoder.sv
// Maps the current ULA usage class plus opcode/funct to the 4-bit ULA code,
// and flags unsupported instructions while decoding.
module ula_decoder
  import mips_pkg::*;
(
  input  ula_cls_t    cls,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  ula_control,
  output logic        illegal
);

  always_comb begin
    ula_control = ULA_AND;
    illegal     = 1'b0;
    case (cls)
      ULA_CLS_ADD: ula_control = ULA_ADD;
      ULA_CLS_SUB: ula_control = ULA_SUB;
      ULA_CLS_DECODE: begin
        ula_control = ULA_ADD;
        case (opcode)
          OP_RTYPE: illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT});
          OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      ULA_CLS_RTYPE: begin
        case (funct)
          FN_ADD:  ula_control = ULA_ADD;
          FN_SUB:  ula_control = ULA_SUB;
          FN_AND:  ula_control = ULA_AND;
          FN_OR:   ula_control = ULA_OR;
          FN_NOR:  ula_control = ULA_NOR;
          FN_SLT:  ula_control = ULA_SLT;
          default: ula_control = ULA_AND;
        endcase
      end
      ULA_CLS_ITYPE: begin
        case (opcode)
          OP_ANDI: ula_control = ULA_AND;
          OP_ORI:  ula_control = ULA_OR;
          OP_SLTI: ula_control = ULA_SLT;
          default: ula_control = ULA_ADD;
        endcase
      end
      default: ula_control = ULA_AND;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and decodes state into datapath selects and write enables.
module controle_multiciclo
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic       ext_zero,
  output logic [1:0] PCSource,
  output logic [3:0] ULAcontrol,
  output logic       illegal_op
);

  state_t   state_q, state_d;
  logic     bne_q, bne_d;
  ula_cls_t cls;
  logic     illegal;
  logic     mem_rdy;
  logic     branch_take;

  assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bne_q   <= bne_d;
    end
  end

  // Kept apart from the main decode so the illegal flag does not loop back.
  always_comb begin
    cls = ULA_CLS_NONE;
    case (state_q)
      S_FETCH, S_MEMADR: cls = ULA_CLS_ADD;
      S_DECODE:          cls = ULA_CLS_DECODE;
      S_EXEC:            cls = ULA_CLS_RTYPE;
      S_BRANCH:          cls = ULA_CLS_SUB;
      S_IEXEC:           cls = ULA_CLS_ITYPE;
      default:           cls = ULA_CLS_NONE;
    endcase
  end

  ula_decoder u_ula_decoder (
    .cls         (cls),
    .opcode      (opcode),
    .funct       (funct),
    .ula_control (ULAcontrol),
    .illegal     (illegal)
  );

  always_comb begin
    state_d     = state_q;
    bne_d       = bne_q;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ULASrcA     = 1'b0;
    ULASrcB     = 2'b00;
    ext_zero    = 1'b0;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    branch_take = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ULASrcB = 2'b01;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ULASrcB = 2'b11;
        // Branch flavour is captured here; opcode is not trusted in BRANCH.
        bne_d   = (opcode == OP_BNE);
        if (illegal) begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:                          state_d = S_EXEC;
            OP_LW, OP_SW:                      state_d = S_MEMADR;
            OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
            OP_J:                              state_d = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
            default:                           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        ULASrcA = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ULASrcA     = 1'b1;
        PCSource    = 2'b01;
        branch_take = bne_q ? ~zero : zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        ULASrcA  = 1'b1;
        ULASrcB  = 2'b10;
        ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI);
        state_d  = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    pc_en = PCWrite | branch_take;
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized instruction stream against a phase-name reference model of the
// multi-cycle control unit, including async resets injected mid-load.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PCWrite, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ULASrcA, ext_zero, illegal_op;
  logic [1:0] ULASrcB, PCSource;
  logic [3:0] ULAcontrol;
  logic [19:0] dut_vec;

  int checks = 0;
  int errors = 0;

  controle_multiciclo #(.MEM_WAIT(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .pc_en      (pc_en),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ULASrcA    (ULASrcA),
    .ULASrcB    (ULASrcB),
    .ext_zero   (ext_zero),
    .PCSource   (PCSource),
    .ULAcontrol (ULAcontrol),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  assign dut_vec = {PCWrite, pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                    RegWrite, ULASrcA, ULASrcB, ext_zero, PCSource, ULAcontrol, illegal_op};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h (PCW pc_en IorD MRd MWr IRW RDst M2R RW SrcA SrcB ext PCSrc ULA ill)",
               tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h27 || fn == 6'h2A;
    return op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02 ||
           op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A;
  endfunction

  function automatic logic [3:0] r_code(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic [3:0] i_code(input logic [5:0] op);
    case (op)
      6'h0C: return 4'd0;
      6'h0D: return 4'd1;
      6'h0A: return 4'd7;
      default: return 4'd2;
    endcase
  endfunction

  function automatic string next_phase(input string p, input logic [5:0] op,
                                       input logic [5:0] fn, input logic mr);
    if (p == "IDLE") return "FETCH";
    if (p == "FETCH") begin
      if (mr) return "DECODE";
      return "FETCH";
    end
    if (p == "DECODE") begin
      if (!legal(op, fn)) return "FETCH";
      if (op == 6'h00) return "EXEC";
      if (op == 6'h23 || op == 6'h2B) return "MEMADR";
      if (op == 6'h04 || op == 6'h05) return "BRANCH";
      if (op == 6'h02) return "JUMP";
      return "IEXEC";
    end
    if (p == "MEMADR") begin
      if (op == 6'h23) return "MEMRD";
      return "MEMWR";
    end
    if (p == "MEMRD") begin
      if (mr) return "MEMWB";
      return "MEMRD";
    end
    if (p == "MEMWR") begin
      if (mr) return "FETCH";
      return "MEMWR";
    end
    if (p == "EXEC") return "ALUWB";
    if (p == "IEXEC") return "IWB";
    return "FETCH";
  endfunction

  function automatic logic [19:0] expect_vec(input string p, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z, input logic mr);
    logic pcw, pce, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ext, ill;
    logic [1:0] srcb, pcsrc;
    logic [3:0] ula;
    {pcw, pce, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ext, ill} = '0;
    srcb = 2'b00; pcsrc = 2'b00; ula = 4'd0;
    if (p == "FETCH") begin
      mrd = 1'b1; srcb = 2'b01; ula = 4'd2; irw = mr; pcw = mr; pce = mr;
    end else if (p == "DECODE") begin
      srcb = 2'b11; ula = 4'd2; ill = !legal(op, fn);
    end else if (p == "MEMADR") begin
      srca = 1'b1; srcb = 2'b10; ula = 4'd2;
    end else if (p == "MEMRD") begin
      mrd = 1'b1; iord = 1'b1;
    end else if (p == "MEMWB") begin
      m2r = 1'b1; rw = 1'b1;
    end else if (p == "MEMWR") begin
      mwr = 1'b1; iord = 1'b1;
    end else if (p == "EXEC") begin
      srca = 1'b1; ula = r_code(fn);
    end else if (p == "ALUWB") begin
      rdst = 1'b1; rw = 1'b1;
    end else if (p == "BRANCH") begin
      srca = 1'b1; ula = 4'd6; pcsrc = 2'b01; pce = (op == 6'h04) ? z : ~z;
    end else if (p == "JUMP") begin
      pcw = 1'b1; pce = 1'b1; pcsrc = 2'b10;
    end else if (p == "IEXEC") begin
      srca = 1'b1; srcb = 2'b10; ext = (op == 6'h0C || op == 6'h0D); ula = i_code(op);
    end else if (p == "IWB") begin
      rw = 1'b1;
    end
    return {pcw, pce, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, ext, pcsrc, ula, ill};
  endfunction

  logic [5:0] ops [12];
  logic [5:0] fns [8];
  string      ph;
  logic [5:0] iop, ifn;
  int         rst_left;
  int         mid_resets;

  initial begin
    ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h03};
    reset      = 1'b1;
    opcode     = '0;
    funct      = '0;
    zero       = 1'b0;
    mem_ready  = 1'b1;
    ph         = "IDLE";
    iop        = '0;
    ifn        = '0;
    rst_left   = 3;
    mid_resets = 0;
    #1;
    check("reset_async", dut_vec, 20'h0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock);
      #1;
      if (reset) ph = "IDLE";
      else       ph = next_phase(ph, iop, ifn, mem_ready);

      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b0;
      end else if (ph == "MEMRD" && $urandom_range(3) == 0) begin
        reset = 1'b1;
        rst_left = 3;
        ph = "IDLE";
        mid_resets++;
      end

      if (ph == "DECODE") begin
        iop = ops[$urandom_range(11)];
        ifn = (iop == 6'h00) ? fns[$urandom_range(7)] : 6'($urandom);
      end

      if (ph == "DECODE" || ph == "EXEC" || ph == "IEXEC" || ph == "MEMADR") begin
        opcode = iop;
        funct  = ifn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      zero      = 1'($urandom);
      mem_ready = ($urandom_range(9) < 6);
      #1;
      check({"out_", ph}, dut_vec, expect_vec(ph, iop, ifn, zero, mem_ready));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
